// File: rtl/gelato_fetch_scheduler_if.sv
// Fetch request channel between the warp scheduler and the instruction fetch stage.
// The scheduler drives the request; fetch answers with fetch_ready.
interface gelato_fetch_scheduler_if #(
  parameter int unsigned WARP_NUM_WIDTH  = 2,
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned SPLIT_NUM_WIDTH = 2
);
  logic                       fetch_valid;
  logic                       fetch_ready;
  logic [PC_WIDTH-1:0]        fetch_pc;
  logic [WARP_NUM_WIDTH-1:0]  fetch_warp_num;
  logic [SPLIT_NUM_WIDTH-1:0] fetch_split_num;

  modport master (
    output fetch_valid,
    output fetch_pc,
    output fetch_warp_num,
    output fetch_split_num,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_pc,
    input  fetch_warp_num,
    input  fetch_split_num,
    output fetch_ready
  );
endinterface

// File: rtl/gelato_fetch_scheduler.sv
// Round-robin warp scheduler: grants one eligible warp per cycle to fetch and keeps
// it blocked (in flight) until decode re-activates it through the split table.
module gelato_fetch_scheduler #(
  parameter int unsigned WARP_NUM        = 4,
  parameter int unsigned WARP_NUM_WIDTH  = 2,
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned SPLIT_NUM_WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                rdy,
  input  logic                                flush,
  input  logic [WARP_NUM-1:0]                 warp_valid,
  input  logic [WARP_NUM*PC_WIDTH-1:0]        warp_pc,
  input  logic [WARP_NUM*SPLIT_NUM_WIDTH-1:0] warp_split_num,
  input  logic                                activate_valid,
  input  logic [WARP_NUM_WIDTH-1:0]           activate_warp_num,
  gelato_fetch_scheduler_if.master            fetch,
  output logic [WARP_NUM-1:0]                 inflight
);

  logic [WARP_NUM_WIDTH-1:0]  rr_ptr;
  logic [WARP_NUM-1:0]        eligible;
  logic [WARP_NUM-1:0]        grant_mask;
  logic [WARP_NUM-1:0]        act_mask;
  logic                       slot_free;
  logic                       grant_any;
  logic [WARP_NUM_WIDTH-1:0]  grant_idx;
  logic [WARP_NUM_WIDTH-1:0]  cand;
  logic [PC_WIDTH-1:0]        pc_arr    [WARP_NUM];
  logic [SPLIT_NUM_WIDTH-1:0] split_arr [WARP_NUM];

  always_comb begin
    for (int unsigned i = 0; i < WARP_NUM; i++) begin
      pc_arr[i]    = warp_pc[i*PC_WIDTH +: PC_WIDTH];
      split_arr[i] = warp_split_num[i*SPLIT_NUM_WIDTH +: SPLIT_NUM_WIDTH];
    end
  end

  // Scan from the farthest offset down to rr_ptr+1 so the nearest eligible warp
  // is the last one written; offset WARP_NUM wraps to rr_ptr itself (lowest priority).
  always_comb begin
    eligible  = warp_valid & ~inflight;
    slot_free = ~fetch.fetch_valid | fetch.fetch_ready;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = WARP_NUM; k > 0; k--) begin
      cand = rr_ptr + WARP_NUM_WIDTH'(k);
      if (eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_mask = '0;
    act_mask   = '0;
    if (slot_free && grant_any)
      grant_mask[grant_idx] = 1'b1;
    if (activate_valid)
      act_mask[activate_warp_num] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch.fetch_valid     <= 1'b0;
      fetch.fetch_pc        <= '0;
      fetch.fetch_warp_num  <= '0;
      fetch.fetch_split_num <= '0;
      inflight              <= '0;
      rr_ptr                <= '1;
    end else if (rdy) begin
      if (flush) begin
        inflight          <= '0;
        fetch.fetch_valid <= 1'b0;
      end else begin
        // Set after clear: an activate racing a fresh grant refers to the older instance.
        inflight <= (inflight & ~act_mask) | grant_mask;
        if (slot_free) begin
          if (grant_any) begin
            fetch.fetch_valid     <= 1'b1;
            fetch.fetch_pc        <= pc_arr[grant_idx];
            fetch.fetch_warp_num  <= grant_idx;
            fetch.fetch_split_num <= split_arr[grant_idx];
            rr_ptr                <= grant_idx;
          end else begin
            fetch.fetch_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/gelato_fetch_scheduler.md
Name: gelato_fetch_scheduler

Overview:
Round-robin warp scheduler between the split-table PC outputs and the instruction fetch stage. Each cycle it picks one eligible warp, presents that warp's PC and split-table entry number to fetch through a valid/ready handshake, and marks the warp in flight. The warp is blocked until decode re-activates it via the split table's activate strobe. Sequences fetch so that at most one instruction per warp is outstanding before the split/branch is resolved.

Parameters:
WARP_NUM, 4, number of warps; power of two, >= 2
WARP_NUM_WIDTH, 2, log2(WARP_NUM)
PC_WIDTH, 32, program counter width
SPLIT_NUM_WIDTH, 2, width of a split-table entry number

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global enable; when 0, all state holds
flush  in  1  synchronous: clears all in-flight flags and drops the output slot
warp_valid  in  WARP_NUM  per-warp PC-table entry valid
warp_pc  in  WARP_NUM*PC_WIDTH  per-warp PC; warp i at bits [i*PC_WIDTH +: PC_WIDTH]
warp_split_num  in  WARP_NUM*SPLIT_NUM_WIDTH  per-warp selected split-table entry
activate_valid  in  1  re-activate a warp (decode resolved its instruction)
activate_warp_num  in  WARP_NUM_WIDTH  warp to re-activate
fetch_valid  out  1  fetch request valid
fetch_ready  in  1  fetch stage accepts request
fetch_pc  out  PC_WIDTH  PC of granted warp
fetch_warp_num  out  WARP_NUM_WIDTH  granted warp
fetch_split_num  out  SPLIT_NUM_WIDTH  split-table entry of granted warp
inflight  out  WARP_NUM  per-warp in-flight flag (debug/perf)

Behaviour:
- Reset (async, rst_n=0): fetch_valid=0, fetch_pc=0, fetch_warp_num=0, fetch_split_num=0, inflight=0, rr_ptr=WARP_NUM-1, so warp 0 has first priority.
- rdy=0: no register changes. fetch outputs hold, and handshakes and activates that cycle are ignored.
- Eligible[i] = warp_valid[i] & ~inflight[i]. Eligibility is computed from registered inflight only.
- Slot free = ~fetch_valid | fetch_ready.
- Grant: if the slot is free and any warp is eligible, pick the first eligible warp scanning rr_ptr+1, rr_ptr+2, ... with modulo-WARP_NUM wrap.
- On the next edge after a grant:
  - fetch_valid<=1.
  - fetch_pc, fetch_warp_num and fetch_split_num are latched from the granted warp.
  - inflight[g]<=1.
  - rr_ptr<=g.
- Grant latency is 1 cycle: eligible in cycle N gives fetch_valid in cycle N+1.
- If the slot is free and no warp is eligible: fetch_valid<=0, and the data registers hold their previous values.
- Backpressure: while fetch_valid=1 and fetch_ready=0, all fetch_* outputs are stable and no new grant is made.
- Back-to-back: if fetch_ready=1 while fetch_valid=1 and another warp is eligible, the next request follows the very next cycle with no bubble.
- Activate: activate_valid=1 clears inflight[activate_warp_num] at the edge. The warp becomes eligible one cycle later.
- Activate on a warp that is not in flight: no effect.
- Activate on the warp currently held in the output slot: inflight is cleared, and the slot is unaffected.
- Simultaneous grant of warp g and activate of warp g: the set wins. inflight[g]=1 after the edge, because the activate referred to the previous instance.
- flush=1 (rdy=1):
  - inflight<=0 and fetch_valid<=0.
  - No grant is made in that cycle, and activate is ignored.
  - rr_ptr holds.
  - flush has priority over every other event.
- A warp whose warp_valid drops while in flight stays in flight until activate or flush.
- All warps in flight: fetch_valid drops to 0 once the last request is accepted.
- Wrap-around: rr_ptr=WARP_NUM-1 scans from warp 0. Only warp rr_ptr eligible: it is granted again (scan includes rr_ptr last).

Test Plan:
- Reset, warp_valid=4'b1111, fetch_ready=1, no activates -> grants warp 0,1,2,3 in consecutive cycles starting 1 cycle after reset release; then fetch_valid=0; inflight=4'b1111.
- Warp 2 in flight, activate_valid=1 activate_warp_num=2 in cycle N -> inflight[2]=0 at N+1; warp 2 granted at N+2 with fetch_pc=warp_pc[2].
- warp_valid=4'b0101, fetch_ready=0 for 5 cycles after first request -> fetch_valid=1, fetch_warp_num=0, PC stable for all 5 cycles; after ready rises, warp 2 is issued next cycle.
- rr_ptr=3, warp_valid=4'b1001, warp 0 just re-activated -> warp 0 granted (wrap) before warp 3 is re-granted.
- Same-edge grant and activate of warp 1 -> inflight[1]=1 after the edge.
- flush during backpressured request of warp 3 with inflight=4'b1010 -> next cycle fetch_valid=0, inflight=0; rdy=0 during flush cycle -> no change.
